// File: rtl/float12_pkg.sv
//------------------------------------------------------------------------------
// float12_pkg : shared constants, word layout and helpers for 12-bit floats
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package float12_pkg;

  localparam int EXP_W    = 5;
  localparam int MAN_W    = 6;
  localparam int GRD_W    = 2;
  localparam int EXP_BIAS = 15;
  localparam int EXP_MAX  = 31;

  localparam logic [11:0] F12_ZERO = 12'h000;
  localparam logic [11:0] F12_MAX  = 12'h7FF;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } f12_t;

  // Leading-zero count of a left-aligned 16-bit field (16 when all zero).
  function automatic logic [4:0] lzc16(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd16;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) n = 5'(15 - i);
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fadd_12_comb.sv
//------------------------------------------------------------------------------
// fadd_12_comb : combinational truncating float adder with saturation flag
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fadd_12_comb #(
  parameter int EXP_W = float12_pkg::EXP_W,
  parameter int MAN_W = float12_pkg::MAN_W,
  parameter int GRD_W = float12_pkg::GRD_W
) (
  input  logic [EXP_W+MAN_W:0] a_i,
  input  logic [EXP_W+MAN_W:0] b_i,
  output logic [EXP_W+MAN_W:0] y_o,
  output logic                 sat_o
);
  import float12_pkg::*;

  localparam int c_W     = 1 + EXP_W + MAN_W;
  localparam int c_SIG_W = 1 + MAN_W + GRD_W;
  localparam logic [EXP_W-1:0] c_EMAX = '1;

  logic             a_s, b_s;
  logic [EXP_W-1:0] a_e, b_e;
  logic [MAN_W-1:0] a_m, b_m;

  logic               w_swap, w_big_s, w_sml_s;
  logic [EXP_W-1:0]   w_big_e, w_sml_e;
  logic [MAN_W-1:0]   w_big_m, w_sml_m;
  logic [7:0]         w_diff;
  logic [c_SIG_W-1:0] w_sig_b, w_sig_s, w_sh, w_dif, w_norm;
  logic [c_SIG_W:0]   w_sum;
  logic [4:0]         w_lz;

  assign {a_s, a_e, a_m} = a_i;
  assign {b_s, b_e, b_m} = b_i;

  always_comb begin
    y_o     = '0;
    sat_o   = 1'b0;
    // Magnitude order follows directly from {exp, man} since the hidden bit is implied.
    w_swap  = (b_i[c_W-2:0] > a_i[c_W-2:0]);
    w_big_s = w_swap ? b_s : a_s;
    w_big_e = w_swap ? b_e : a_e;
    w_big_m = w_swap ? b_m : a_m;
    w_sml_s = w_swap ? a_s : b_s;
    w_sml_e = w_swap ? a_e : b_e;
    w_sml_m = w_swap ? a_m : b_m;
    w_diff  = 8'(w_big_e) - 8'(w_sml_e);
    w_sig_b = {1'b1, w_big_m, {GRD_W{1'b0}}};
    w_sig_s = {1'b1, w_sml_m, {GRD_W{1'b0}}};
    w_sh    = (w_diff >= 8'(c_SIG_W)) ? '0 : (w_sig_s >> w_diff);
    w_sum   = {1'b0, w_sig_b} + {1'b0, w_sh};
    w_dif   = w_sig_b - w_sh;
    w_lz    = lzc16(16'({w_dif, {(16 - c_SIG_W){1'b0}}}));
    w_norm  = w_dif << w_lz;

    if (a_e == '0 && b_e == '0) begin
      y_o = '0;
    end else if (a_e == '0) begin
      y_o = b_i;
    end else if (b_e == '0) begin
      y_o = a_i;
    end else if (w_big_s == w_sml_s) begin
      if (w_sum[c_SIG_W]) begin
        if (w_big_e == c_EMAX) begin
          y_o   = {w_big_s, {(c_W-1){1'b1}}};
          sat_o = 1'b1;
        end else begin
          y_o = {w_big_s, w_big_e + 1'b1, w_sum[c_SIG_W-1 -: MAN_W]};
        end
      end else begin
        y_o = {w_big_s, w_big_e, w_sum[c_SIG_W-2 -: MAN_W]};
      end
    end else if (w_dif == '0) begin
      y_o = '0;
    end else if (8'(w_big_e) <= 8'(w_lz)) begin
      // Underflow flushes silently to +0.
      y_o = '0;
    end else begin
      y_o = {w_big_s, EXP_W'(w_big_e - EXP_W'(w_lz)), w_norm[c_SIG_W-2 -: MAN_W]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/float_acc_12.sv
//------------------------------------------------------------------------------
// float_acc_12 : bias + sum-of-products accumulator with optional ReLU
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module float_acc_12 #(
  parameter int EXP_W = float12_pkg::EXP_W,
  parameter int MAN_W = float12_pkg::MAN_W,
  parameter int GRD_W = float12_pkg::GRD_W,
  parameter int CNT_W = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 valid_i,
  input  logic [EXP_W+MAN_W:0] data_i,
  input  logic                 last_i,
  input  logic [EXP_W+MAN_W:0] bias_i,
  input  logic                 relu_en_i,
  output logic                 valid_o,
  output logic [EXP_W+MAN_W:0] data_o,
  output logic [CNT_W-1:0]     cnt_o,
  output logic                 ovf_o
);

  localparam int c_W = 1 + EXP_W + MAN_W;

  logic [c_W-1:0]   r_acc;
  logic             r_first;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf_acc;

  logic [c_W-1:0]   w_op_a;
  logic [c_W-1:0]   w_sum;
  logic             w_sat;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_op_a    = r_first ? bias_i : r_acc;
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

  fadd_12_comb #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W),
    .GRD_W (GRD_W)
  ) u_fadd (
    .a_i   (w_op_a),
    .b_i   (data_i),
    .y_o   (w_sum),
    .sat_o (w_sat)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_acc     <= '0;
      r_first   <= 1'b1;
      r_cnt     <= '0;
      r_ovf_acc <= 1'b0;
      valid_o   <= 1'b0;
      data_o    <= '0;
      cnt_o     <= '0;
      ovf_o     <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (valid_i) begin
        if (!last_i) begin
          r_acc     <= w_sum;
          r_first   <= 1'b0;
          r_cnt     <= w_cnt_inc;
          r_ovf_acc <= r_ovf_acc | w_sat;
        end else begin
          // ReLU only touches negative nonzero results; +0 already has sign 0.
          data_o    <= (relu_en_i && w_sum[c_W-1]) ? '0 : w_sum;
          cnt_o     <= w_cnt_inc;
          ovf_o     <= r_ovf_acc | w_sat;
          valid_o   <= 1'b1;
          r_acc     <= '0;
          r_cnt     <= '0;
          r_ovf_acc <= 1'b0;
          r_first   <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire
